alu_mul_sequencer: RTL and testbench



---
 rtl/alu_mul_sequencer.sv | 60 ++++++
 tb/tb_alu_mul_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: shift-and-add multiplier that borrows the shared ALU for its additions
module alu_mul_sequencer #(
  parameter int n = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [n-1:0] op_a,
  input  logic [n-1:0] op_b,
  input  logic [n-1:0] alu_result,
  output logic [n-1:0] alu_a,
  output logic [n-1:0] alu_b,
  output logic [3:0]   alu_op,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] product
);
  localparam int cw = (n > 1) ? $clog2(n) : 1;
  typedef enum logic [1:0] {st_idle, st_run, st_done} state_t;
  state_t state, state_nx;
  logic [n-1:0] mcand, mplier, acc;
  logic [cw-1:0] count;
  logic last;
  // stop once no multiplier bits remain, so small multipliers finish early
  assign last = ((mplier >> 1) == '0) || (count == cw'(n - 1));
  always_comb begin
    state_nx = (state == st_idle) ? (start ? st_run : st_idle) :
               (state == st_run)  ? (last ? st_done : st_run) : st_idle;
    alu_a    = (state == st_run) ? acc : '0;
    alu_b    = (state == st_run && mplier[0]) ? mcand : '0;
    alu_op   = (state == st_run) ? 4'b0010 : 4'b0111;
    busy     = state != st_idle;
    done     = state == st_done;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= st_idle;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      state <= state_nx;
      if (state == st_idle && start) begin
        mcand  <= op_a;
        mplier <= op_b;
        acc    <= '0;
        count  <= '0;
      end
      if (state == st_run) begin
        acc    <= alu_result;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + 1'b1;
        if (last) product <= alu_result;
      end
    end
  end
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: directed scoreboard bench with a behavioural ALU beside the sequencer
module tb_alu_mul_sequencer;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        start = 0;
  logic [63:0] op_a = '0, op_b = '0;
  logic [63:0] alu_result, alu_a, alu_b, product;
  logic [3:0]  alu_op;
  logic        busy, done;
  logic [63:0] q[$];
  int errors = 0;
  int checks = 0;

  alu_mul_sequencer #(.n(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .alu_result(alu_result), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .busy(busy), .done(done), .product(product)
  );

  assign alu_result = (alu_op == 4'b0010) ? alu_a + alu_b :
                      (alu_op == 4'b0111) ? alu_b : alu_a - alu_b;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int kof(input logic [63:0] b);
    int k = 1;
    for (int i = 0; i < 64; i++) if (b[i]) k = i + 1;
    return k;
  endfunction

  // entered at the negedge of RUN cycle 1; leaves at the negedge of the following IDLE cycle
  task automatic wait_done(input int k, input string tag);
    int c = 1;
    logic [63:0] exp;
    chk({tag, "_busy_run"}, 64'(busy), 64'd1);
    while (done !== 1'b1 && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_latency"}, 64'(c), 64'(k + 1));
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_busy_done"}, 64'(busy), 64'd1);
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_queue: observed=empty expected=entry", tag);
      exp = '0;
    end else begin
      exp = q.pop_front();
      chk({tag, "_product"}, product, exp);
    end
    @(negedge clk);
    chk({tag, "_done_low"}, 64'(done), 64'd0);
    chk({tag, "_busy_low"}, 64'(busy), 64'd0);
    chk({tag, "_held"}, product, exp);
  endtask

  task automatic mul(input logic [63:0] a, input logic [63:0] b, input string tag);
    q.push_back(a * b);
    op_a = a;
    op_b = b;
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done(kof(b), tag);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_product", product, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_alu_op", 64'(alu_op), 64'h7);
    chk("rst_alu_a", alu_a, 64'd0);
    chk("rst_alu_b", alu_b, 64'd0);

    q.push_back(64'd15);
    op_a = 3;
    op_b = 5;
    start = 1;
    @(negedge clk);
    start = 0;
    chk("m35_op1", 64'(alu_op), 64'h2);
    chk("m35_b1", alu_b, 64'd3);
    chk("m35_a1", alu_a, 64'd0);
    @(negedge clk);
    chk("m35_b2", alu_b, 64'd0);
    chk("m35_a2", alu_a, 64'd3);
    @(negedge clk);
    chk("m35_op3", 64'(alu_op), 64'h2);
    chk("m35_b3", alu_b, 64'd12);
    @(negedge clk);
    chk("m35_done", 64'(done), 64'd1);
    chk("m35_product", product, q.pop_front());
    @(negedge clk);
    chk("m35_done_low", 64'(done), 64'd0);
    chk("m35_held", product, 64'd15);
    chk("m35_idle_op", 64'(alu_op), 64'h7);

    mul(64'hDEAD, 64'd0, "zero_b");
    mul('1, '1, "all_ones");
    chk("all_ones_value", product, 64'd1);
    mul(64'h1234_5678_9abc_def0, 64'h0fed_cba9_8765_4321, "big");
    mul(64'd1000, 64'd1, "one_b");

    q.push_back(64'd42);
    op_a = 7;
    op_b = 6;
    start = 1;
    @(negedge clk);
    op_a = 9;
    op_b = 9;
    wait_done(3, "collide");
    q.push_back(64'd81);
    @(negedge clk);
    start = 0;
    wait_done(4, "b2b");

    op_a = 2;
    op_b = 64'h80;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    chk("abort_busy_run", 64'(busy), 64'd1);
    rst_n = 0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_product", product, 64'd0);
    rst_n = 1;
    repeat (10) begin
      @(negedge clk);
      chk("abort_no_done", 64'(done), 64'd0);
    end
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
